// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a small gate, samples its response and scores it
// against TRUTH. Optional response capture on `observed` with TRUTH_TABLE_CHECKER_LOG_EN.
module truth_table_checker #(
  parameter int                N      = 2,
  parameter logic [2**N-1:0]   TRUTH  = 4'b1101,
  parameter int                SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dut_out,
  output logic [N-1:0]      vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N:0]        err_count,
  output logic              fail_valid,
  output logic [N-1:0]      first_fail,
  output logic [2**N-1:0]   observed,
  output logic [1:0]        state_dbg
);

  // Handshake: start is a one-cycle request with no ready; it is accepted only
  // in IDLE or DONE and silently dropped while busy. done is a level that holds
  // until the next accepted start or reset.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [N-1:0] LAST_VEC = {N{1'b1}};

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       accept;
  logic       mismatch;
  logic       last_vec;

  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign mismatch  = (dut_out != TRUTH[vec]);
  assign last_vec  = (vec == LAST_VEC);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // With SETTLE=0 there is no wait phase: each vector lives one SAMPLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt <= 4'd1) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (last_vec)         state_next = ST_DONE;
        else if (SETTLE == 0) state_next = ST_SAMPLE;
        else                  state_next = ST_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec        <= '0;
            cnt        <= SETTLE_L;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (last_vec) begin
            vec  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            vec <= vec + 1'b1;
            cnt <= SETTLE_L;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRUTH_TABLE_CHECKER_LOG_EN
  logic [2**N-1:0] obs_q;

  always_ff @(posedge clk) begin
    if (reset)                         obs_q      <= '0;
    else if (accept)                   obs_q      <= '0;
    else if (state == ST_SAMPLE)       obs_q[vec] <= dut_out;
  end

  assign observed = obs_q;
`else
  assign observed = '0;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomised self-checking bench for truth_table_checker at default parameters;
// the gate under test is a lookup table chosen per sweep.
module tb_truth_table_checker;

  localparam int N = 2;
  localparam int SETTLE = 1;
  localparam logic [3:0] TRUTH = 4'b1101;
  localparam int SWEEP_CYCLES = (1 << N) * (SETTLE + 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         dut_out;
  logic [N-1:0] vec;
  logic         busy, done, pass, fail_valid;
  logic [N:0]   err_count;
  logic [N-1:0] first_fail;
  logic [3:0]   observed;
  logic [1:0]   state_dbg;

  logic [3:0]   gate_tbl = 4'b1101;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  exp_q[$];

  truth_table_checker #(.N(N), .TRUTH(TRUTH), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_out(dut_out),
    .vec(vec), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail(first_fail),
    .observed(observed), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always_comb dut_out = gate_tbl[vec];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vec"}, 32'(vec), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"}, 32'(err_count), 0);
    check({tag, "_fv"}, 32'(fail_valid), 0);
    check({tag, "_ff"}, 32'(first_fail), 0);
    check({tag, "_obs"}, 32'(observed), 0);
    check({tag, "_state_idle"}, 32'(state_dbg), 0);
  endtask

  // One full sweep against the table tbl; poke re-pulses start while vec==1.
  task automatic run_sweep(input string tag, input logic [3:0] tbl, input bit poke);
    int          k;
    int          exp_err;
    int          exp_first;
    bit          found;
    logic [31:0] exp_v;
    gate_tbl = tbl;

    exp_err = 0;
    exp_first = 0;
    found = 0;
    for (int i = 0; i < (1 << N); i++) begin
      if (tbl[i] != TRUTH[i]) begin
        exp_err++;
        if (!found) begin
          exp_first = i;
          found = 1;
        end
      end
    end
    exp_q.delete();
    for (int c = 0; c < SWEEP_CYCLES; c++) exp_q.push_back(32'(c / (SETTLE + 1)));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_accept_err_clr"}, 32'(err_count), 0);
    check({tag, "_accept_done_clr"}, 32'(done), 0);
    check({tag, "_accept_fv_clr"}, 32'(fail_valid), 0);

    k = 0;
    while (!done && k < 100) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead;
      check({tag, "_vec_seq"}, 32'(vec), exp_v);
      check({tag, "_busy"}, 32'(busy), 1);
      start = (poke && vec == 2'd1) ? 1'b1 : 1'b0;
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(SWEEP_CYCLES));
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_vec0"}, 32'(vec), 0);
    check({tag, "_err"}, 32'(err_count), 32'(exp_err));
    check({tag, "_fv"}, 32'(fail_valid), 32'(found));
    check({tag, "_ff"}, 32'(first_fail), 32'(exp_first));
    check({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
`ifdef TRUTH_TABLE_CHECKER_LOG_EN
    check({tag, "_obs"}, 32'(observed), 32'(tbl));
`else
    check({tag, "_obs"}, 32'(observed), 0);
`endif
    // Results must hold in DONE.
    repeat (3) @(negedge clk);
    check({tag, "_hold_done"}, 32'(done), 1);
    check({tag, "_hold_err"}, 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run_sweep("or_nb", 4'b1101, 1'b0);
    run_sweep("and", 4'b1000, 1'b0);
    run_sweep("stuck1", 4'b1111, 1'b0);
    run_sweep("restart_fixed", 4'b1101, 1'b0);
    run_sweep("poke", 4'b1000, 1'b1);

    // Abort mid-sweep once vec reaches 2.
    gate_tbl = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 20 && vec != 2'd2; b++) @(negedge clk);
    check("abort_at_vec2", 32'(vec), 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("abort");
    @(negedge clk);
    check_reset_values("abort_stay");
    run_sweep("after_abort", 4'b1101, 1'b0);

    // reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_reset_values("rst_vs_start");

    for (int r = 0; r < 8; r++) run_sweep($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
